// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the ag2048 calculator core.
//   op_t        pending arithmetic operator
//   sh_state_t  display shift-out sequencer states
//   FRAME_BITS  bits per display frame (4 digits x 8 segments)
//   seg_glyph() decimal digit to 7-segment code {dp,g,f,e,d,c,b,a}
package calc_pkg;

   typedef enum logic [2:0] {OP_NONE, OP_ADD, OP_SUB, OP_MUL, OP_DIV} op_t;

   typedef enum logic [1:0] {SH_BITS, SH_IDLE, SH_LATCH} sh_state_t;

   localparam int         FRAME_BITS = 32;
   localparam logic [7:0] SEG_MINUS  = 8'h40;
   localparam logic [7:0] SEG_BLANK  = 8'h00;

   function automatic logic [7:0] seg_glyph(input logic [3:0] d);
      case (d)
         4'd0:    seg_glyph = 8'h3F;
         4'd1:    seg_glyph = 8'h06;
         4'd2:    seg_glyph = 8'h5B;
         4'd3:    seg_glyph = 8'h4F;
         4'd4:    seg_glyph = 8'h66;
         4'd5:    seg_glyph = 8'h6D;
         4'd6:    seg_glyph = 8'h7D;
         4'd7:    seg_glyph = 8'h07;
         4'd8:    seg_glyph = 8'h7F;
         4'd9:    seg_glyph = 8'h6F;
         default: seg_glyph = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/ag2048_calculator_if.sv
// ag2048_calculator_if: Tiny Tapeout tile pin bundle.
//   ena      tile enable
//   ui_in    keypad bit lines [3:0], operator buttons [7:4]
//   uio_in   AC [0], EQ [1], signed mode [6], NEG [7]
//   uo_out   keypad word lines [3:0], sr_data/sr_clk/sr_latch/sr_oe_n [7:4]
//   uio_out  pending-operator LEDs [5:2]
//   uio_oe   bidir output enables
interface ag2048_calculator_if;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/calc_keypad_scan.sv
// calc_keypad_scan: 4x4 keypad row scanner with one-shot key output.
//   clk, rst   clock, async active-high reset
//   cols       keypad bit lines (active-high, asynchronous)
//   rows       one-hot word line drive, row 0 after reset
//   key_vld    one-cycle pulse when a new key is recognised
//   key_code   4*row + col of that key
module calc_keypad_scan #(
   parameter int SCAN_CYCLES = 256
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] cols,
   output logic [3:0] rows,
   output logic       key_vld,
   output logic [3:0] key_code
);
   localparam int            CW   = $clog2(SCAN_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(SCAN_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic [1:0]    row_idx;
   logic [3:0]    col_s1, col_s2;
   logic          found, armed;
   logic [3:0]    code;
   logic [1:0]    col_idx;
   logic          hit, found_now;
   logic [3:0]    code_now;

   assign rows = 4'b0001 << row_idx;

   // First key seen in a scan wins: lowest row, then lowest column.
   always_comb begin
      col_idx   = col_s2[0] ? 2'd0 : col_s2[1] ? 2'd1 : col_s2[2] ? 2'd2 : 2'd3;
      hit       = |col_s2;
      found_now = found | hit;
      code_now  = found ? code : {row_idx, col_idx};
   end

   // Columns are sampled only in the last cycle of a row window, so the
   // two sync stages always reflect the row currently being driven.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         row_idx  <= 2'd0;
         col_s1   <= 4'd0;
         col_s2   <= 4'd0;
         found    <= 1'b0;
         armed    <= 1'b1;
         code     <= 4'd0;
         key_vld  <= 1'b0;
         key_code <= 4'd0;
      end else begin
         col_s1  <= cols;
         col_s2  <= col_s1;
         key_vld <= 1'b0;
         if (cnt == LAST) begin
            cnt     <= '0;
            row_idx <= row_idx + 2'd1;
            if (row_idx == 2'd3) begin
               // End of scan: fire once, re-arm only after a key-free scan.
               key_vld  <= found_now & armed;
               key_code <= code_now;
               armed    <= ~found_now;
               found    <= 1'b0;
            end else if (!found && hit) begin
               found <= 1'b1;
               code  <= {row_idx, col_idx};
            end
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/ag2048_calculator.sv
// ag2048_calculator: four-function 8-bit calculator tile.
//   clk     system clock
//   rst_n   async reset, active-high despite the name
//   bus     tile pins (ag2048_calculator_if.slave): keypad, buttons,
//           74HC595 display chain, operator LEDs
module ag2048_calculator
   import calc_pkg::*;
#(
   parameter int SCAN_CYCLES = 256
) (
   input logic                clk,
   input logic                rst_n,
   ag2048_calculator_if.slave bus
);
   // button order: [3:0] add,sub,mul,div  [4] AC  [5] EQ  [6] NEG
   logic [6:0] btn_raw, b_s1, b_s2, b_s3, b_rise;
   logic       mode;
   logic [3:0] rows, key_code;
   logic       key_vld;
   logic [7:0] cur, acc, eq_res, mag_a, mag_b, mag_q, mag;
   op_t        op, op_sel;
   logic       fresh;
   logic [11:0] cat, lim;
   logic [19:0] dd;
   logic [31:0] disp_word, shreg;
   sh_state_t  sh_state, sh_nxt;
   logic [5:0] bit_cnt, nxt_cnt;
   logic       sr_data, sr_clk, sr_latch, sr_oe_n;
   logic       nxt_data, nxt_clk, nxt_latch, load;
   logic       unused_pins;

   assign btn_raw     = {bus.uio_in[7], bus.uio_in[1], bus.uio_in[0], bus.ui_in[7:4]};
   assign mode        = bus.uio_in[6];
   assign unused_pins = &{1'b0, bus.ena, bus.uio_in[5:2]};

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         b_s1 <= '0;
         b_s2 <= '0;
         b_s3 <= '0;
      end else begin
         b_s1 <= btn_raw;
         b_s2 <= b_s1;
         b_s3 <= b_s2;
      end
   end
   assign b_rise = b_s2 & ~b_s3;

   calc_keypad_scan #(.SCAN_CYCLES(SCAN_CYCLES)) u_kp (
      .clk(clk), .rst(rst_n), .cols(bus.ui_in[3:0]), .rows(rows),
      .key_vld(key_vld), .key_code(key_code)
   );

   always_comb begin
      op_sel = b_rise[0] ? OP_ADD : b_rise[1] ? OP_SUB : b_rise[2] ? OP_MUL : OP_DIV;
      cat    = {4'd0, cur} * 12'd10 + {8'd0, key_code};
      lim    = mode ? 12'd127 : 12'd255;
      // Signed divide on magnitudes so the quotient truncates toward zero.
      mag_a  = (mode && acc[7]) ? (~acc + 8'd1) : acc;
      mag_b  = (mode && cur[7]) ? (~cur + 8'd1) : cur;
      mag_q  = (mag_b == 8'd0) ? 8'd0 : mag_a / mag_b;
      case (op)
         OP_ADD:  eq_res = acc + cur;
         OP_SUB:  eq_res = acc - cur;
         OP_MUL:  eq_res = 8'(acc * cur);
         OP_DIV:  eq_res = (mode && (acc[7] ^ cur[7])) ? (~mag_q + 8'd1) : mag_q;
         default: eq_res = cur;
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         cur   <= 8'd0;
         acc   <= 8'd0;
         op    <= OP_NONE;
         fresh <= 1'b1;
      end else if (b_rise[4]) begin
         cur   <= 8'd0;
         acc   <= 8'd0;
         op    <= OP_NONE;
         fresh <= 1'b1;
      end else if (b_rise[5]) begin
         if (op != OP_NONE) begin
            cur   <= eq_res;
            op    <= OP_NONE;
            fresh <= 1'b1;
         end
      end else if (|b_rise[3:0]) begin
         op <= op_sel;
         // A second operator before any digit just swaps the operator.
         if (!(op != OP_NONE && fresh)) begin
            acc   <= cur;
            fresh <= 1'b1;
         end
      end else if (b_rise[6]) begin
         if (mode) cur <= ~cur + 8'd1;
      end else if (key_vld && key_code <= 4'd9) begin
         if (fresh) begin
            cur   <= {4'd0, key_code};
            fresh <= 1'b0;
         end else if (cat <= lim) begin
            cur <= cat[7:0];
         end
      end
   end

   // Display image, mode applied live to the stored bits.
   always_comb begin
      mag = (mode && cur[7]) ? (~cur + 8'd1) : cur;
      dd  = {12'd0, mag};
      for (int i = 0; i < 8; i++) begin
         if (dd[11:8]  > 4'd4) dd[11:8]  = dd[11:8]  + 4'd3;
         if (dd[15:12] > 4'd4) dd[15:12] = dd[15:12] + 4'd3;
         if (dd[19:16] > 4'd4) dd[19:16] = dd[19:16] + 4'd3;
         dd = dd << 1;
      end
      disp_word[31:24] = (mode && cur[7]) ? SEG_MINUS : SEG_BLANK;
      disp_word[23:16] = (dd[19:16] != 4'd0) ? seg_glyph(dd[19:16]) : SEG_BLANK;
      disp_word[15:8]  = (dd[19:12] != 8'd0) ? seg_glyph(dd[15:12]) : SEG_BLANK;
      disp_word[7:0]   = seg_glyph(dd[11:8]);
   end

   // Shift-out sequencer: 64 half-bit cycles, idle, latch = 66-cycle frame.
   always_comb begin
      sh_nxt    = sh_state;
      nxt_cnt   = bit_cnt;
      nxt_data  = 1'b0;
      nxt_clk   = 1'b0;
      nxt_latch = 1'b0;
      load      = 1'b0;
      case (sh_state)
         SH_BITS: begin
            load     = (bit_cnt == 6'd0);
            nxt_data = load ? disp_word[FRAME_BITS-1] : shreg[5'd31 - bit_cnt[5:1]];
            nxt_clk  = bit_cnt[0];
            nxt_cnt  = bit_cnt + 6'd1;
            if (bit_cnt == 6'(2*FRAME_BITS - 1)) sh_nxt = SH_IDLE;
         end
         SH_IDLE:  sh_nxt = SH_LATCH;
         default: begin
            nxt_latch = 1'b1;
            sh_nxt    = SH_BITS;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         sh_state <= SH_BITS;
         bit_cnt  <= 6'd0;
         shreg    <= '0;
         sr_data  <= 1'b0;
         sr_clk   <= 1'b0;
         sr_latch <= 1'b0;
         sr_oe_n  <= 1'b1;
      end else begin
         sh_state <= sh_nxt;
         bit_cnt  <= nxt_cnt;
         if (load) shreg <= disp_word;
         sr_data  <= nxt_data;
         sr_clk   <= nxt_clk;
         sr_latch <= nxt_latch;
         if (nxt_latch) sr_oe_n <= 1'b0;
      end
   end

   assign bus.uo_out  = {sr_oe_n, sr_latch, sr_clk, sr_data, rows};
   assign bus.uio_out = {2'b00, op == OP_DIV, op == OP_MUL, op == OP_SUB, op == OP_ADD, 2'b00};
   assign bus.uio_oe  = 8'b0011_1100;
endmodule

// File: tb/tb_ag2048_calculator.sv
// tb_ag2048_calculator: directed test of the calculator tile with a keypad
// model and a 74HC595 chain model capturing the latched display word.
module tb_ag2048_calculator;
   localparam int SCAN = 16;
   localparam int SCAN_ALL = 4 * SCAN;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_down = 1'b0;
   logic [1:0] key_row = 2'd0, key_col = 2'd0;
   logic [3:0] op_btn = 4'd0;
   logic       ac = 1'b0, eq = 1'b0, neg = 1'b0, mode = 1'b0;
   int         n_vec = 0, n_bad = 0;
   int         latch_cnt = 0;
   logic [31:0] sr_shift, sr_out;

   ag2048_calculator_if bus();

   ag2048_calculator #(.SCAN_CYCLES(SCAN)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   always #5 clk = ~clk;

   assign bus.ena    = 1'b1;
   assign bus.ui_in  = {op_btn, (key_down && bus.uo_out[key_row]) ? (4'b0001 << key_col) : 4'b0000};
   assign bus.uio_in = {neg, mode, 4'b0000, eq, ac};

   wire sr_data_w  = bus.uo_out[4];
   wire sr_clk_w   = bus.uo_out[5];
   wire sr_latch_w = bus.uo_out[6];

   always @(posedge sr_clk_w)   sr_shift <= {sr_shift[30:0], sr_data_w};
   always @(posedge sr_latch_w) begin
      sr_out    <= sr_shift;
      latch_cnt <= latch_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic key(input int k);
      @(negedge clk);
      key_row  = 2'(k / 4);
      key_col  = 2'(k % 4);
      key_down = 1'b1;
      repeat (3 * SCAN_ALL) @(negedge clk);
      key_down = 1'b0;
      repeat (3 * SCAN_ALL) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] o, input logic a, input logic e, input logic n);
      @(negedge clk);
      op_btn = o; ac = a; eq = e; neg = n;
      repeat (8) @(negedge clk);
      op_btn = 4'd0; ac = 1'b0; eq = 1'b0; neg = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   // Two latches guarantee the captured frame was snapshotted after the action.
   task automatic frame(input string tag, input logic [31:0] exp);
      int start = latch_cnt;
      int t = 0;
      while (latch_cnt < start + 2 && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (latch_cnt < start + 2) chk({tag, "_timeout"}, 32'(latch_cnt - start), 32'd2);
      chk(tag, sr_out, exp);
   endtask

   initial begin
      #2 rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_uo_out", {24'd0, bus.uo_out}, 32'h81);
      chk("rst_leds", {24'd0, bus.uio_out}, 32'h00);
      chk("uio_oe", {24'd0, bus.uio_oe}, 32'h3C);
      rst_n = 1'b0;
      repeat (65) @(posedge clk);
      #1 chk("pre_latch", {30'd0, bus.uo_out[7:6]}, 32'b10);
      @(posedge clk);
      #1 chk("first_latch", {30'd0, bus.uo_out[7:6]}, 32'b01);
      #2 chk("first_frame", sr_out, 32'h0000003F);

      // 12 + 3
      key(1); key(2);
      press(4'b0001, 0, 0, 0);
      chk("led_add", {24'd0, bus.uio_out}, 32'h04);
      key(3);
      press(4'b0000, 0, 1, 0);
      frame("add_15", 32'h0000066D);
      chk("led_clear", {24'd0, bus.uio_out}, 32'h00);

      // signed 3 - 5, then NEG
      press(4'b0000, 1, 0, 0);
      mode = 1'b1;
      key(3);
      press(4'b0010, 0, 0, 0);
      key(5);
      press(4'b0000, 0, 1, 0);
      frame("sub_m2", 32'h4000005B);
      press(4'b0000, 0, 0, 1);
      frame("neg_2", 32'h0000005B);

      // unsigned 200 + 100 wraps to 44
      press(4'b0000, 1, 0, 0);
      mode = 1'b0;
      key(2); key(0); key(0);
      press(4'b0001, 0, 0, 0);
      key(1); key(0); key(0);
      press(4'b0000, 0, 1, 0);
      frame("add_wrap_44", 32'h00006666);

      // entry limit 255, extra digit ignored; mode pin reinterprets display
      press(4'b0000, 1, 0, 0);
      key(2); key(5); key(5);
      frame("entry_255", 32'h005B6D6D);
      key(5);
      frame("entry_limit", 32'h005B6D6D);
      mode = 1'b1;
      frame("live_mode_m1", 32'h40000006);
      mode = 1'b0;

      // divide by zero
      press(4'b0000, 1, 0, 0);
      key(7);
      press(4'b1000, 0, 0, 0);
      key(0);
      press(4'b0000, 0, 1, 0);
      frame("div_zero", 32'h0000003F);

      // signed -7 / 2 = -3
      press(4'b0000, 1, 0, 0);
      mode = 1'b1;
      key(7);
      press(4'b0000, 0, 0, 1);
      frame("neg_7", 32'h40000007);
      press(4'b1000, 0, 0, 0);
      key(2);
      press(4'b0000, 0, 1, 0);
      frame("div_m3", 32'h4000004F);
      mode = 1'b0;

      // held key registers once
      press(4'b0000, 1, 0, 0);
      @(negedge clk);
      key_row = 2'd0; key_col = 2'd1; key_down = 1'b1;
      repeat (10 * SCAN_ALL) @(negedge clk);
      key_down = 1'b0;
      repeat (3 * SCAN_ALL) @(negedge clk);
      frame("held_once", 32'h00000006);
      key(2);
      frame("after_held", 32'h0000065B);

      // AC wins over EQ in the same cycle
      press(4'b0000, 1, 0, 0);
      key(5);
      press(4'b0001, 0, 0, 0);
      key(3);
      chk("led_add2", {24'd0, bus.uio_out}, 32'h04);
      press(4'b0000, 1, 1, 0);
      frame("ac_over_eq", 32'h0000003F);
      chk("ac_leds", {24'd0, bus.uio_out}, 32'h00);

      // 12 * 3 = 36
      key(1); key(2);
      press(4'b0100, 0, 0, 0);
      chk("led_mul", {24'd0, bus.uio_out}, 32'h10);
      key(3);
      press(4'b0000, 0, 1, 0);
      frame("mul_36", 32'h00004F7D);

      // reset mid-frame clears state and restarts framing
      repeat (20) @(negedge clk);
      rst_n = 1'b1;
      #1 chk("midrst_uo_out", {24'd0, bus.uo_out}, 32'h81);
      @(negedge clk);
      rst_n = 1'b0;
      frame("post_rst", 32'h0000003F);
      chk("uio_oe_end", {24'd0, bus.uio_oe}, 32'h3C);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
